// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the shared seven-segment display scheduler.
// Holds FSM encoding, anode/segment codes and the BCD helper functions.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    CONVERT = 2'd2,
    SHOW    = 2'd3
  } state_e;

  localparam logic [2:0] ONES_EN = 3'b110;
  localparam logic [2:0] TENS_EN = 3'b101;
  localparam logic [2:0] HUND_EN = 3'b011;
  localparam logic [2:0] ALL_OFF = 3'b111;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h98;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to each BCD nibble before a shift.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_scheduler_bin2bcd.sv
// Sequential 8-bit double dabble: one load cycle, then 8 shift/add-3 steps.
// done pulses for one cycle once bcd holds the final result.
module bin2bcd_seq
  import seven_seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0] sh;
  logic [2:0] cnt;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        {bcd, sh} <= {dabble_adj(bcd), sh} << 1;
        cnt       <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seven_seg_scheduler.sv
// Round-robin sharing of a 3-digit multiplexed seven-segment display.
// Granted byte is converted to BCD and scanned out with leading-zero blanking.
module seven_seg_scheduler
  import seven_seg_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int DWELL_CYCLES  = 12000000,
  parameter int SCAN_DIV      = 12000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                       CLK_12MHz,
  input  logic                       RST_N,
  input  logic [N_SRC-1:0]           REQ,
  input  logic [8*N_SRC-1:0]         DATA,
  output logic [N_SRC-1:0]           GNT,
  output logic [$clog2(N_SRC)-1:0]   SRC_IDX,
  output logic                       CONV_BUSY,
  output logic [7:0]                 SevenSegment,
  output logic [2:0]                 SevenSegmentEnable
);

  localparam int IW = $clog2(N_SRC);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int PW = $clog2(SCAN_DIV);

  state_e          state, state_n;
  logic [IW-1:0]   ptr, win;
  logic [DW-1:0]   dwell;
  logic [PW-1:0]   pres, pres_n;
  logic [1:0]      dig, dig_n;
  logic [11:0]     disp, disp_n, bcd;
  logic [7:0]      cap_byte, seg_n;
  logic [2:0]      en_n;
  logic [3:0]      hund, tens, ones;
  logic            done, start, found;
  logic            blank_h, blank_t;

  // Round-robin search starting just above the last winner.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!found && REQ[(int'(ptr) + k) % N_SRC]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % N_SRC);
      end
    end
  end

  assign start    = (state == ARB) && (|REQ);
  assign cap_byte = DATA[8*int'(win) +: 8];

  bin2bcd_seq u_b2b (
    .clk   (CLK_12MHz),
    .rst_n (RST_N),
    .start (start),
    .bin   (cap_byte),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|REQ) state_n = ARB;
      ARB:     state_n = (|REQ) ? CONVERT : IDLE;
      CONVERT: if (done) state_n = SHOW;
      SHOW: begin
        if (!REQ[SRC_IDX] ||
            dwell == DW'(DWELL_CYCLES - 1))
          state_n = ARB;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ptr       <= IW'(N_SRC - 1);
      GNT       <= '0;
      SRC_IDX   <= '0;
      CONV_BUSY <= 1'b0;
      disp      <= '0;
      dwell     <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        ARB: begin
          if (|REQ) begin
            GNT       <= N_SRC'(1) << win;
            SRC_IDX   <= win;
            ptr       <= win;
            CONV_BUSY <= 1'b1;
          end else begin
            GNT <= '0;
          end
        end
        CONVERT: begin
          if (done) begin
            disp      <= bcd;
            CONV_BUSY <= 1'b0;
            dwell     <= '0;
          end
        end
        SHOW:    dwell <= dwell + 1'b1;
        default: ;
      endcase
    end
  end

  // Scan values are derived from the post-edge digit and BCD so both
  // outputs always describe the same digit.
  always_comb begin
    disp_n = disp;
    if (state == CONVERT && done) disp_n = bcd;
    pres_n = pres + 1'b1;
    dig_n  = dig;
    if (pres == PW'(SCAN_DIV - 1)) begin
      pres_n = '0;
      dig_n  = (dig == 2'd2) ? 2'd0 : dig + 2'd1;
    end
    hund    = disp_n[11:8];
    tens    = disp_n[7:4];
    ones    = disp_n[3:0];
    blank_h = (BLANK_LEADING != 0) && (hund == 4'd0);
    blank_t = blank_h && (tens == 4'd0);
    unique case (dig_n)
      2'd0: begin
        en_n  = ONES_EN;
        seg_n = seg_decode(ones);
      end
      2'd1: begin
        en_n  = TENS_EN;
        seg_n = blank_t ? SEG_BLANK : seg_decode(tens);
      end
      default: begin
        en_n  = HUND_EN;
        seg_n = blank_h ? SEG_BLANK : seg_decode(hund);
      end
    endcase
  end

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      pres               <= '0;
      dig                <= '0;
      SevenSegment       <= SEG_BLANK;
      SevenSegmentEnable <= ALL_OFF;
    end else if (state_n == IDLE) begin
      pres               <= '0;
      dig                <= '0;
      SevenSegment       <= SEG_BLANK;
      SevenSegmentEnable <= ALL_OFF;
    end else begin
      pres               <= pres_n;
      dig                <= dig_n;
      SevenSegment       <= seg_n;
      SevenSegmentEnable <= en_n;
    end
  end

endmodule
